scene_loader: RTL

- Consumes the byte stream from the UART receiver (`rx_data`/`rx_done`) and parses framed command packets.
- Packets carry triangle vertices, colour and rotation angle for the vertex-shader stage.
- Validated updates go into a pending shadow set and are committed to the active outputs only at frame start, so the vertex stage and the rasteriser never see a half-updated triangle mid-frame.

---
 rtl/scene_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/scene_loader.sv
// Parses framed host packets (SYNC, CMD, payload, XOR checksum) from the UART byte stream.
// Accepted updates wait in a shadow set and are committed to the active outputs only at frame start.
module scene_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_start,
    output logic [15:0] v0_x,
    output logic [15:0] v0_y,
    output logic [15:0] v1_x,
    output logic [15:0] v1_y,
    output logic [15:0] v2_x,
    output logic [15:0] v2_y,
    output logic [5:0]  color,
    output logic [7:0]  angle,
    output logic        scene_valid,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, CSUM} state_t;

    // Packed index order: v0x, v0y, v1x, v1y, v2x, v2y from index 0 upward.
    localparam logic [5:0][15:0] RST_V = {16'hFFC0, 16'h0040, 16'hFFC0,
                                          16'hFFC0, 16'h0040, 16'h0000};

    state_t            state, state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [7:0]        cmd_reg;
    logic [7:0]        run_xor;
    logic [3:0]        remain;
    logic [3:0]        idx;
    logic [7:0]        stage [12];
    logic [5:0][15:0]  sh_v, act_v;
    logic [5:0]        sh_color, act_color;
    logic [7:0]        sh_angle, act_angle;
    logic              pending;

    logic timeout, cmd_known, accept, reject;

    assign timeout   = (state != IDLE) && (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES));
    assign cmd_known = (rx_data == 8'h01) || (rx_data == 8'h02) || (rx_data == 8'h03);
    assign accept    = !timeout && rx_valid && (state == CSUM) && (rx_data == run_xor);
    assign reject    = timeout
                     || (rx_valid && (state == CMD)  && !cmd_known)
                     || (rx_valid && (state == CSUM) && (rx_data != run_xor));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE:    if (rx_data == SYNC_BYTE) state_next = CMD;
                CMD:     state_next = cmd_known ? PAYLOAD : IDLE;
                PAYLOAD: if (remain == 4'd1) state_next = CSUM;
                CSUM:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Inter-byte gap counter; only meaningful while a packet is open.
    always_ff @(posedge clk) begin
        if (reset || rx_valid || state == IDLE) tmo_cnt <= '0;
        else                                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg <= '0;
            run_xor <= '0;
            remain  <= '0;
            idx     <= '0;
            for (int i = 0; i < 12; i++) stage[i] <= '0;
        end else if (rx_valid && !timeout) begin
            if (state == CMD && cmd_known) begin
                cmd_reg <= rx_data;
                run_xor <= rx_data;
                remain  <= (rx_data == 8'h01) ? 4'd12 : 4'd1;
                idx     <= '0;
            end else if (state == PAYLOAD) begin
                stage[idx] <= rx_data;
                run_xor    <= run_xor ^ rx_data;
                remain     <= remain - 4'd1;
                idx        <= idx + 4'd1;
            end
        end
    end

    // Commit copies the shadow as registered before this edge, so a packet
    // accepted in the same cycle as frame_start stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_v        <= RST_V;
            act_v       <= RST_V;
            sh_color    <= 6'h3F;
            act_color   <= 6'h3F;
            sh_angle    <= '0;
            act_angle   <= '0;
            pending     <= 1'b0;
            scene_valid <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (frame_start && pending) begin
                act_v       <= sh_v;
                act_color   <= sh_color;
                act_angle   <= sh_angle;
                scene_valid <= 1'b1;
            end
            if (accept) begin
                case (cmd_reg)
                    8'h01: for (int i = 0; i < 6; i++) sh_v[i] <= {stage[2*i+1], stage[2*i]};
                    8'h02: sh_color <= stage[0][5:0];
                    8'h03: sh_angle <= stage[0];
                    default: ;
                endcase
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
            if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign v0_x  = act_v[0];
    assign v0_y  = act_v[1];
    assign v1_x  = act_v[2];
    assign v1_y  = act_v[3];
    assign v2_x  = act_v[4];
    assign v2_y  = act_v[5];
    assign color = act_color;
    assign angle = act_angle;

endmodule
